alu_mem_sequencer: RTL

Multi-cycle instruction sequencer that drives the 16-bit ALU and the 256-word data memory of the simple CPU. It accepts one instruction at a time over a valid/ready handshake and orders the memory read, ALU evaluation and memory write-back. It returns the result and flags over a second valid/ready handshake. It sits between the instruction source (testbench or fetch stage) and the shared ALU/memory datapath; it is the only master of both.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/seq_decode.sv | 39 +++
 rtl/alu_mem_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU/memory sequencer.
// Opcodes, FSM state encoding and response flag bit positions.
package cpu_pkg;

    localparam logic [3:0] OP_NOP     = 4'b0000;
    localparam logic [3:0] OP_STORE   = 4'b0010;
    localparam logic [3:0] OP_LOAD    = 4'b0011;
    localparam logic [3:0] OP_COMPUTE = 4'b0100;

    localparam int FLG_C = 3;
    localparam int FLG_V = 2;
    localparam int FLG_N = 1;
    localparam int FLG_Z = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_CALC,
        S_WB,
        S_RSP
    } state_t;

endpackage

// File: rtl/seq_decode.sv
// Instruction word decoder for the sequencer.
// Classifies the opcode and splits out the ALU and address fields.
module seq_decode
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [15:0]       cmd,
    output logic              is_nop,
    output logic              is_store,
    output logic              is_load,
    output logic              is_compute,
    output logic              is_illegal,
    output logic [2:0]        op,
    output logic              sub,
    output logic [ADDR_W-1:0] addr
);

    assign op   = cmd[11:9];
    assign sub  = cmd[8];
    assign addr = cmd[ADDR_W-1:0];

    // One-hot opcode classification; anything unlisted is illegal.
    always_comb begin
        is_nop     = 1'b0;
        is_store   = 1'b0;
        is_load    = 1'b0;
        is_compute = 1'b0;
        is_illegal = 1'b0;
        unique case (cmd[15:12])
            OP_NOP:     is_nop     = 1'b1;
            OP_STORE:   is_store   = 1'b1;
            OP_LOAD:    is_load    = 1'b1;
            OP_COMPUTE: is_compute = 1'b1;
            default:    is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_mem_sequencer.sv
// Multi-cycle sequencer mastering the shared ALU and data memory.
// Orders read, ALU evaluation and write-back for one instruction at a time.
module alu_mem_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr_cmd,
    input  logic [DATA_W-1:0] instr_number,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_sub,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    input  logic              alu_overflow,
    input  logic              alu_no,
    input  logic              alu_zo,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err
);

    state_t state, state_nxt;

    logic [15:0]       cmd_reg;
    logic [DATA_W-1:0] number_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] opa_reg;
    logic [DATA_W-1:0] opb_reg;
    logic [2:0]        op_reg;
    logic              sub_reg;
    logic [DATA_W-1:0] result_reg;
    logic [3:0]        flags_reg;
    logic              err_reg;

    logic [15:0]       dec_cmd;
    logic              d_nop, d_store, d_load, d_compute, d_illegal;
    logic [2:0]        d_op;
    logic              d_sub;
    logic [ADDR_W-1:0] d_addr;
    logic              accept;
    logic [3:0]        load_flags;
    logic [3:0]        alu_flags;

    // In IDLE the offered word is classified, afterwards the latched one.
    assign dec_cmd = (state == S_IDLE) ? instr_cmd : cmd_reg;

    seq_decode #(.ADDR_W(ADDR_W)) u_decode (
        .cmd        (dec_cmd),
        .is_nop     (d_nop),
        .is_store   (d_store),
        .is_load    (d_load),
        .is_compute (d_compute),
        .is_illegal (d_illegal),
        .op         (d_op),
        .sub        (d_sub),
        .addr       (d_addr)
    );

    assign instr_ready = (state == S_IDLE);
    assign accept      = instr_valid && instr_ready;

    assign load_flags = {2'b00, mem_rdata[DATA_W-1], mem_rdata == '0};

    // Pack the ALU flags into their response bit positions.
    always_comb begin
        alu_flags        = '0;
        alu_flags[FLG_C] = alu_cout;
        alu_flags[FLG_V] = alu_overflow;
        alu_flags[FLG_N] = alu_no;
        alu_flags[FLG_Z] = alu_zo;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (d_nop || d_illegal) state_nxt = S_RSP;
                    else                    state_nxt = S_RD;
                end
            end
            S_RD:   state_nxt = S_CAP;
            S_CAP:  state_nxt = d_load ? S_RSP : S_CALC;
            S_CALC: state_nxt = d_store ? S_WB : S_RSP;
            S_WB:   state_nxt = S_RSP;
            S_RSP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers loaded as the instruction advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_reg    <= '0;
            number_reg <= '0;
            addr_reg   <= '0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            op_reg     <= '0;
            sub_reg    <= 1'b0;
            result_reg <= '0;
            flags_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd_reg    <= instr_cmd;
                        number_reg <= instr_number;
                        addr_reg   <= d_addr;
                        result_reg <= '0;
                        flags_reg  <= '0;
                        err_reg    <= d_illegal;
                    end
                end
                S_CAP: begin
                    if (d_load) begin
                        result_reg <= mem_rdata;
                        flags_reg  <= load_flags;
                    end else begin
                        opa_reg <= number_reg;
                        opb_reg <= mem_rdata;
                        op_reg  <= d_op;
                        sub_reg <= d_sub;
                    end
                end
                S_CALC: begin
                    result_reg <= alu_result;
                    flags_reg  <= alu_flags;
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_en = (state == S_RD) && !rst;
    assign mem_wr_en = (state == S_WB) && !rst;
    assign mem_addr  = (mem_rd_en || mem_wr_en) ? addr_reg : '0;
    assign mem_wdata = mem_wr_en ? result_reg : '0;

    assign alu_a   = rst ? '0 : opa_reg;
    assign alu_b   = rst ? '0 : opb_reg;
    assign alu_op  = rst ? '0 : op_reg;
    assign alu_sub = !rst && sub_reg;

    assign rsp_valid  = (state == S_RSP) && !rst;
    assign rsp_result = rsp_valid ? result_reg : '0;
    assign rsp_flags  = rsp_valid ? flags_reg : '0;
    assign rsp_err    = rsp_valid && err_reg;

endmodule
